// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg: shared limits, FSM state encoding and width helper
// for the multi-core DRAM arbiter slice.
package dram_arbiter_pkg;

  localparam int MAX_NCORES = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Ceiling log2, never below 1 so index registers stay at least 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: core-side request bus and DRAM-side mux outputs.
// Ports: req/wren/addr/wdata (cores), dacq/rvalid/stats, mem_* (DRAM).
interface dram_arbiter_if #(
  parameter int NCORES = 2,
  parameter int AW     = 8,
  parameter int DW     = 8
);

  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    wren;
  logic [NCORES*AW-1:0] addr;
  logic [NCORES*DW-1:0] wdata;
  logic [NCORES-1:0]    dacq;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_data;
  logic                 mem_wren;
  logic [NCORES-1:0]    rvalid;
  logic [NCORES*32-1:0] stats;

  modport slave (
    input  req, wren, addr, wdata,
    output dacq, mem_addr, mem_data,
    output mem_wren, rvalid, stats
  );

  modport master (
    output req, wren, addr, wdata,
    input  dacq, mem_addr, mem_data,
    input  mem_wren, rvalid, stats
  );

endinterface

// File: rtl/dram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports: i_req vector, i_start index -> o_found, o_idx (first set from start).
module rr_pick
  import dram_arbiter_pkg::*;
#(
  parameter int N = 2,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  int          w_j;
  logic [W-1:0] w_i;

  // Walk from the far end back toward i_start so the closest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    w_i     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_start) + k;
      if (w_j >= N) w_j = w_j - N;
      w_i = W'(w_j);
      if (i_req[w_i]) begin
        o_found = 1'b1;
        o_idx   = w_i;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin-with-hold owner of one shared DRAM port.
// Ports: CLK, rst (async high), bus (slave: core requests, DRAM mux, stats).
// Optional DRAM_ARB_STATS_EN builds per-core granted-cycle counters.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int NCORES  = 2,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MAXHOLD = 16
) (
  input logic           CLK,
  input logic           rst,
  dram_arbiter_if.slave bus
);

  localparam int LW = clog2(NCORES);
  localparam int HW = clog2(MAXHOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAXHOLD);
  localparam logic [HW-1:0] HLIM =
    (MAXHOLD == 0) ? '0 : HW'(MAXHOLD - 1);
  localparam logic [LW-1:0] LTOP = LW'(NCORES - 1);

  arb_state_t        r_state;
  logic [LW-1:0]     r_own;
  logic [LW-1:0]     r_last;
  logic [HW-1:0]     r_hold;
  logic [NCORES-1:0] r_dacq;
  logic [NCORES-1:0] r_rvalid;

  logic              w_busy;
  logic              w_oreq;
  logic              w_owren;
  logic              w_preempt;
  logic              w_found;
  logic              w_grant;
  logic [LW-1:0]     w_idx;
  logic [LW-1:0]     w_start;
  logic [NCORES-1:0] w_req;

  assign w_busy  = (r_state == ARB_BUSY);
  assign w_oreq  = bus.req[r_own];
  assign w_owren = bus.wren[r_own];

  // In BUSY r_last == r_own, so one search from r_last+1 serves
  // both the IDLE grant and the handoff; the owner is masked out so
  // a preempted core cannot re-win its own slot.
  assign w_start = (r_last == LTOP) ? '0 : r_last + 1'b1;
  assign w_req   = w_busy ?
    (bus.req & ~(NCORES'(1) << r_own)) : bus.req;

  // hold counts completed owned cycles, so the limit cycle is HLIM.
  assign w_preempt = (MAXHOLD != 0) && (r_hold >= HLIM);
  assign w_grant   = w_found &&
    (!w_busy || !w_oreq || w_preempt);

  rr_pick #(
    .N (NCORES),
    .W (LW)
  ) u_pick (
    .i_req   (w_req),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_own    <= '0;
      r_last   <= LTOP;
      r_hold   <= '0;
      r_dacq   <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= (w_busy && w_oreq && !w_owren) ?
        (NCORES'(1) << r_own) : '0;
      unique case (r_state)
        ARB_IDLE, ARB_BUSY: begin
          if (w_grant) begin
            r_state <= ARB_BUSY;
            r_own   <= w_idx;
            r_last  <= w_idx;
            r_dacq  <= NCORES'(1) << w_idx;
            r_hold  <= '0;
          end else if (w_busy && w_oreq) begin
            if (r_hold != HMAX) r_hold <= r_hold + 1'b1;
          end else if (w_busy) begin
            r_state <= ARB_IDLE;
            r_dacq  <= '0;
            r_hold  <= '0;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.dacq     = r_dacq;
  assign bus.rvalid   = r_rvalid;
  assign bus.mem_addr =
    w_busy ? bus.addr[r_own*AW +: AW] : '0;
  assign bus.mem_data =
    w_busy ? bus.wdata[r_own*DW +: DW] : '0;
  assign bus.mem_wren = w_busy & w_oreq & w_owren;

`ifdef DRAM_ARB_STATS_EN
  logic [31:0] r_stats [NCORES];

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCORES; i++) r_stats[i] <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++)
        if (r_dacq[i]) r_stats[i] <= r_stats[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < NCORES; g++) begin : g_stats
    assign bus.stats[g*32 +: 32] = r_stats[g];
  end
`else
  assign bus.stats = '0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed checks of grant, handoff, read/write,
// preemption, 4-core rotation and async reset.
module tb_dram_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  dram_arbiter_if #(.NCORES(2), .AW(8), .DW(8)) b0();
  dram_arbiter_if #(.NCORES(2), .AW(8), .DW(8)) b1();
  dram_arbiter_if #(.NCORES(4), .AW(8), .DW(8)) b2();

  dram_arbiter #(
    .NCORES(2), .AW(8), .DW(8), .MAXHOLD(16)
  ) u0 (.CLK(clk), .rst(rst), .bus(b0));

  dram_arbiter #(
    .NCORES(2), .AW(8), .DW(8), .MAXHOLD(4)
  ) u1 (.CLK(clk), .rst(rst), .bus(b1));

  dram_arbiter #(
    .NCORES(4), .AW(8), .DW(8), .MAXHOLD(16)
  ) u2 (.CLK(clk), .rst(rst), .bus(b2));

  // single-port synchronous DRAM, 1-cycle read latency
  logic [7:0] ram [256];
  logic [7:0] q;

  always @(posedge clk) begin
    if (b0.mem_wren) ram[b0.mem_addr] <= b0.mem_data;
    q <= ram[b0.mem_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr();
    b0.req = '0; b0.wren = '0; b0.addr = '0; b0.wdata = '0;
    b1.req = '0; b1.wren = '0; b1.addr = '0; b1.wdata = '0;
    b2.req = '0; b2.wren = '0; b2.addr = '0; b2.wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clr();
    #1;
    checks++;
    if (b0.dacq !== 2'b00) begin
      $display("FAIL reset_dacq: got %b want 00", b0.dacq);
      fails++;
    end
    checks++;
    if (b0.rvalid !== 2'b00) begin
      $display("FAIL reset_rvalid: got %b want 00", b0.rvalid);
      fails++;
    end
    checks++;
    if (b0.mem_wren !== 1'b0 || b0.mem_addr !== 8'h00) begin
      $display("FAIL reset_mem: got wren %b addr %h want 0 00",
        b0.mem_wren, b0.mem_addr);
      fails++;
    end
    checks++;
    if (b0.stats !== 64'd0) begin
      $display("FAIL reset_stats: got %h want 0", b0.stats);
      fails++;
    end
    checks++;
    if (b2.dacq !== 4'b0000) begin
      $display("FAIL reset_dacq4: got %b want 0000", b2.dacq);
      fails++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_grant();
    logic [31:0] exp_s;
    b0.addr = {8'h22, 8'h11};
    b0.req  = 2'b01;
    #1;
    checks++;
    if (b0.mem_addr !== 8'h00 || b0.dacq !== 2'b00) begin
      $display("FAIL idle_gate: got addr %h dacq %b want 00 00",
        b0.mem_addr, b0.dacq);
      fails++;
    end
    @(negedge clk);
    checks++;
    if (b0.dacq !== 2'b01) begin
      $display("FAIL grant_dacq: got %b want 01", b0.dacq);
      fails++;
    end
    checks++;
    if (b0.mem_addr !== 8'h11 || b0.mem_wren !== 1'b0) begin
      $display("FAIL grant_mux: got addr %h wren %b want 11 0",
        b0.mem_addr, b0.mem_wren);
      fails++;
    end
    b0.req = 2'b00;
    @(negedge clk);
    checks++;
    if (b0.dacq !== 2'b00 || b0.mem_addr !== 8'h00) begin
      $display("FAIL release_idle: got dacq %b addr %h want 00 00",
        b0.dacq, b0.mem_addr);
      fails++;
    end
`ifdef DRAM_ARB_STATS_EN
    exp_s = 32'd1;
`else
    exp_s = 32'd0;
`endif
    checks++;
    if (b0.stats[31:0] !== exp_s) begin
      $display("FAIL stats0: got %0d want %0d", b0.stats[31:0], exp_s);
      fails++;
    end
  endtask

  task automatic test_handoff();
    do_reset();
    b0.addr = {8'h22, 8'h11};
    b0.req  = 2'b11;
    @(negedge clk);
    checks++;
    if (b0.dacq !== 2'b01) begin
      $display("FAIL both_req_first: got %b want 01", b0.dacq);
      fails++;
    end
    b0.req = 2'b10;
    @(negedge clk);
    checks++;
    if (b0.dacq !== 2'b10) begin
      $display("FAIL handoff: got %b want 10", b0.dacq);
      fails++;
    end
    checks++;
    if (b0.mem_addr !== 8'h22) begin
      $display("FAIL handoff_addr: got %h want 22", b0.mem_addr);
      fails++;
    end
  endtask

  task automatic test_read();
    b0.wren = 2'b01;
    #1;
    checks++;
    if (b0.mem_wren !== 1'b0) begin
      $display("FAIL wren_gate: got %b want 0", b0.mem_wren);
      fails++;
    end
    b0.wren  = 2'b10;
    b0.addr  = {8'h2A, 8'h11};
    b0.wdata = {8'h5C, 8'h00};
    #1;
    checks++;
    if (b0.mem_wren !== 1'b1 || b0.mem_addr !== 8'h2A ||
        b0.mem_data !== 8'h5C) begin
      $display("FAIL write_mux: got %b %h %h want 1 2a 5c",
        b0.mem_wren, b0.mem_addr, b0.mem_data);
      fails++;
    end
    @(negedge clk);
    checks++;
    if (b0.rvalid !== 2'b00) begin
      $display("FAIL rvalid_write: got %b want 00", b0.rvalid);
      fails++;
    end
    b0.wren = 2'b00;
    @(negedge clk);
    checks++;
    if (b0.rvalid !== 2'b10) begin
      $display("FAIL rvalid_read: got %b want 10", b0.rvalid);
      fails++;
    end
    checks++;
    if (q !== 8'h5C) begin
      $display("FAIL read_q: got %h want 5c", q);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    b0.wren = 2'b10;
    #1;
    checks++;
    if (b0.mem_wren !== 1'b1) begin
      $display("FAIL pend_write: got %b want 1", b0.mem_wren);
      fails++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (b0.dacq !== 2'b00 || b0.mem_wren !== 1'b0) begin
      $display("FAIL async_rst: got dacq %b wren %b want 00 0",
        b0.dacq, b0.mem_wren);
      fails++;
    end
    checks++;
    if (b0.rvalid !== 2'b00) begin
      $display("FAIL async_rvalid: got %b want 00", b0.rvalid);
      fails++;
    end
    checks++;
    if (b0.stats !== 64'd0) begin
      $display("FAIL async_stats: got %h want 0", b0.stats);
      fails++;
    end
    @(negedge clk);
    rst = 1'b0;
    clr();
  endtask

  task automatic test_preempt();
    logic [1:0] exp_p [9];
    exp_p = '{2'b01, 2'b01, 2'b01, 2'b01,
              2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    b1.req = 2'b01;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (b1.dacq !== exp_p[i]) begin
        $display("FAIL preempt[%0d]: got %b want %b",
          i, b1.dacq, exp_p[i]);
        fails++;
      end
      if (i == 0) b1.req = 2'b11;
    end
    b1.req = 2'b00;
  endtask

  task automatic test_rr4();
    logic [3:0] exp_r [5];
    exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    b2.req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (b2.dacq !== exp_r[i]) begin
        $display("FAIL rr4[%0d]: got %b want %b",
          i, b2.dacq, exp_r[i]);
        fails++;
      end
      b2.req = 4'hF & ~exp_r[i];
    end
    b2.req = 4'h0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    clr();
    test_reset();
    test_grant();
    test_handoff();
    test_read();
    test_reset_mid();
    test_preempt();
    test_rr4();
    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule
